// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: multi-lane ready/valid stage with 2-entry skid buffer; optional zero-latency path via PIPE_STAGE_BUF_BYPASS_EN
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0] st, st_n;
  logic [LANES-1:0] head_v, skid_v, hv_n, sv_n;
  logic [LANES*WIDTH-1:0] head_d, skid_d, hd_n, sd_n, in_m;
  logic ir_r, acc, drn, byp;
  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign in_m[i*WIDTH +: WIDTH] = in_valid[i] ? in_data[i*WIDTH +: WIDTH] : '0;
  end
  assign acc = ir_r && |in_valid && !flush;
  assign drn = |head_v && out_ready;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
  assign byp = (st == EMPTY) && out_ready && acc;
  assign out_valid = byp ? in_valid : head_v;
  assign out_data  = byp ? in_m : head_d;
`else
  assign byp = 1'b0;
  assign out_valid = head_v;
  assign out_data  = head_d;
`endif
  assign in_ready  = ir_r;
  assign occupancy = st;
  // next-state: flush clears everything, FULL only drains, otherwise accept/drain move bundles FIFO-wise
  always_comb begin
    st_n = st;
    hv_n = head_v;
    hd_n = head_d;
    sv_n = skid_v;
    sd_n = skid_d;
    if (flush) begin
      st_n = EMPTY;
      hv_n = '0;
      hd_n = '0;
      sv_n = '0;
      sd_n = '0;
    end else if (st == FULL) begin
      if (drn) begin
        st_n = ONE;
        hv_n = skid_v;
        hd_n = skid_d;
        sv_n = '0;
        sd_n = '0;
      end
    end else if (acc && !byp) begin
      if (st == EMPTY || drn) begin
        st_n = ONE;
        hv_n = in_valid;
        hd_n = in_m;
      end else begin
        st_n = FULL;
        sv_n = in_valid;
        sd_n = in_m;
      end
    end else if (drn) begin
      st_n = EMPTY;
      hv_n = '0;
      hd_n = '0;
    end
  end
  // state registers; in_ready is registered so it never depends on same-cycle out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= EMPTY;
      head_v <= '0;
      head_d <= '0;
      skid_v <= '0;
      skid_d <= '0;
      ir_r   <= 1'b1;
    end else begin
      st     <= st_n;
      head_v <= hv_n;
      head_d <= hd_n;
      skid_v <= sv_n;
      skid_d <= sd_n;
      ir_r   <= st_n != FULL;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed table, corner sequences and random run against a queue model
module tb_pipe_stage_buf;
  logic clk = 0;
  logic reset = 1;
  logic flush = 0;
  logic [1:0] in_valid = '0;
  logic [63:0] in_data = '0;
  logic in_ready;
  logic [1:0] out_valid;
  logic [63:0] out_data;
  logic out_ready = 0;
  logic [1:0] occupancy;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic fl;
    logic [1:0] iv;
    logic [63:0] id;
    logic ordy;
    logic [1:0] ov;
    logic [63:0] od;
    logic [1:0] occ;
    logic ir;
  } vec_t;
  typedef struct {
    logic [1:0] v;
    logic [63:0] d;
  } bnd_t;
  vec_t tbl[$];
  bnd_t q[$];
  bit m_ir;

  pipe_stage_buf #(.WIDTH(32), .LANES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic fl, logic [1:0] iv, logic [63:0] id, logic ordy,
                              logic [1:0] ov, logic [63:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  function automatic logic [63:0] masked(logic [1:0] iv, logic [63:0] d);
    return {iv[1] ? d[63:32] : 32'h0, iv[0] ? d[31:0] : 32'h0};
  endfunction

  task automatic model_edge();
    bit drain, accept;
    bnd_t b;
    drain = q.size() > 0 && out_ready;
    accept = m_ir && |in_valid && !flush;
    if (flush) q.delete();
    else begin
      if (drain) void'(q.pop_front());
      if (accept) begin
        b.v = in_valid;
        b.d = masked(in_valid, in_data);
        q.push_back(b);
      end
    end
    m_ir = q.size() != 2;
  endtask

  initial begin
    tbl.push_back(mk(0, 2'b11, {32'h2, 32'h1}, 1, 2'b11, {32'h2, 32'h1}, 1, 1));
    tbl.push_back(mk(0, 2'b01, {32'hDEAD, 32'h5}, 1, 2'b01, {32'h0, 32'h5}, 1, 1));
    tbl.push_back(mk(0, 2'b00, 64'h0, 1, 2'b00, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 64'h1, 0, 2'b01, 64'h1, 1, 1));
    tbl.push_back(mk(0, 2'b01, 64'h2, 0, 2'b01, 64'h1, 2, 0));
    tbl.push_back(mk(0, 2'b01, 64'h3, 0, 2'b01, 64'h1, 2, 0));
    tbl.push_back(mk(0, 2'b00, 64'h0, 1, 2'b01, 64'h2, 1, 1));
    tbl.push_back(mk(0, 2'b00, 64'h0, 1, 2'b00, 64'h0, 0, 1));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 2'b10, {32'(k), 32'hFFFF}, 1, 2'b10, {32'(k), 32'h0}, 1, 1));
    tbl.push_back(mk(0, 2'b00, 64'h0, 1, 2'b00, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 64'h7, 0, 2'b01, 64'h7, 1, 1));
    tbl.push_back(mk(0, 2'b01, 64'h8, 0, 2'b01, 64'h7, 2, 0));
    tbl.push_back(mk(1, 2'b11, {32'h9, 32'h9}, 0, 2'b00, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 64'h0, 1, 2'b00, 64'h0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst ov", 64'(out_valid), 64'h0);
    chk("rst od", out_data, 64'h0);
    chk("rst occ", 64'(occupancy), 64'h0);
    chk("rst ir", 64'(in_ready), 64'h1);
    reset = 0;

    foreach (tbl[k]) begin
      flush = tbl[k].fl;
      in_valid = tbl[k].iv;
      in_data = tbl[k].id;
      out_ready = tbl[k].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d ov", k), 64'(out_valid), 64'(tbl[k].ov));
      if (tbl[k].ov != 0 || tbl[k].fl) chk($sformatf("t%0d od", k), out_data, tbl[k].od);
      chk($sformatf("t%0d occ", k), 64'(occupancy), 64'(tbl[k].occ));
      chk($sformatf("t%0d ir", k), 64'(in_ready), 64'(tbl[k].ir));
    end
    flush = 0;

    in_valid = 2'b11;
    out_ready = 0;
    in_data = {32'hA1, 32'hA0};
    @(posedge clk);
    #1 in_data = {32'hB1, 32'hB0};
    @(posedge clk);
    #1 in_valid = 2'b00;
    chk("full occ", 64'(occupancy), 64'h2);
    @(negedge clk);
    reset = 1;
    #1;
    chk("arst ov", 64'(out_valid), 64'h0);
    chk("arst od", out_data, 64'h0);
    chk("arst occ", 64'(occupancy), 64'h0);
    chk("arst ir", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1 reset = 0;
    in_valid = 2'b11;
    in_data = {32'h44, 32'h33};
    out_ready = 1;
    #1;
`ifndef PIPE_STAGE_BUF_BYPASS_EN
    chk("lat0 ov", 64'(out_valid), 64'h0);
`endif
    @(posedge clk);
    #1;
    chk("lat1 ov", 64'(out_valid), 64'h3);
    chk("lat1 od", out_data, {32'h44, 32'h33});
    in_valid = 2'b00;

    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    q.delete();
    m_ir = 1;
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 19) == 0);
      in_valid = 2'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("r%0d ov", n), 64'(out_valid), 64'(q.size() > 0 ? q[0].v : 2'b00));
      if (q.size() > 0) chk($sformatf("r%0d od", n), out_data, q[0].d);
      chk($sformatf("r%0d occ", n), 64'(occupancy), 64'(q.size()));
      chk($sformatf("r%0d ir", n), 64'(in_ready), 64'(m_ir));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
